// File: rtl/sdram_bist.sv
// rtl/sdram_bist.sv - SDRAM write/readback self-test master driving the sdram_controller request port
//
// Ports:
//   fpga_clk, fpga_reset_n          clock, asynchronous active-low reset
//   start, pattern_sel              launch a test (sampled in IDLE only); 0 = LFSR, 1 = address pattern
//   busy, done                      test in progress; one-cycle end-of-test pulse
//   pass, timeout                   result of last test, held until the next accepted start
//   err_count                       saturating mismatch count of last test
//   first_err_addr, first_err_data  address and read data of the first mismatch
//   fpga_addr, fpga_wr_en,          request to the controller
//   fpga_wr_data, fpga_rd_en,
//   fpga_req
//   fpga_rd_data, fpga_ack          completion from the controller

module sdram_bist #(
    parameter int unsigned FPGA_ADDR_WIDTH = 23,
    parameter int unsigned FPGA_DATA_WIDTH = 32,
    parameter int unsigned ADDR_FIRST      = 0,
    parameter int unsigned ADDR_LAST       = 1023,
    parameter logic [31:0] LFSR_SEED       = 32'hACE1_2468,
    parameter int unsigned ERR_CNT_WIDTH   = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 4095
) (
    input  logic                       fpga_clk,
    input  logic                       fpga_reset_n,
    input  logic                       start,
    input  logic                       pattern_sel,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       timeout,
    output logic [ERR_CNT_WIDTH-1:0]   err_count,
    output logic [FPGA_ADDR_WIDTH-1:0] first_err_addr,
    output logic [FPGA_DATA_WIDTH-1:0] first_err_data,
    output logic [FPGA_ADDR_WIDTH-1:0] fpga_addr,
    output logic                       fpga_wr_en,
    output logic [FPGA_DATA_WIDTH-1:0] fpga_wr_data,
    output logic                       fpga_rd_en,
    output logic                       fpga_req,
    input  logic [FPGA_DATA_WIDTH-1:0] fpga_rd_data,
    input  logic                       fpga_ack
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_GAP = 3'd2,
        RD_REQ = 3'd3,
        RD_GAP = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam int unsigned                WD_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FPGA_ADDR_WIDTH-1:0] FIRST_A   = FPGA_ADDR_WIDTH'(ADDR_FIRST);
    localparam logic [FPGA_ADDR_WIDTH-1:0] LAST_A    = FPGA_ADDR_WIDTH'(ADDR_LAST);
    localparam logic [WD_WIDTH-1:0]        WD_LAST   = WD_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]                LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0]                ADDR_XOR  = 32'h5A5A_5A5A;

    state_t                     state_q, state_d;
    logic [FPGA_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]                lfsr_q;
    logic                       psel_q;
    logic [WD_WIDTH-1:0]        wd_q;
    logic [ERR_CNT_WIDTH-1:0]   err_q, err_d;
    logic [FPGA_ADDR_WIDTH-1:0] ferr_addr_q;
    logic [FPGA_DATA_WIDTH-1:0] ferr_data_q;
    logic                       pass_q;
    logic                       timeout_q;

    logic                       in_req;
    logic                       acked;
    logic                       last_addr;
    logic                       wd_expire;
    logic                       mismatch;
    logic                       launch;
    logic [31:0]                lfsr_next;
    logic [FPGA_DATA_WIDTH-1:0] exp_data;

    assign in_req    = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign acked     = in_req && fpga_ack;
    assign last_addr = (addr_q == LAST_A);
    // Watchdog fires in the last allowed request cycle if that cycle has no ack either.
    assign wd_expire = in_req && !fpga_ack && (wd_q == WD_LAST);
    assign launch    = (state_q == IDLE) && start;

    assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
    // Same generator feeds write data and the readback reference, so both phases replay one sequence.
    assign exp_data  = FPGA_DATA_WIDTH'(psel_q ? (32'(addr_q) ^ ADDR_XOR) : lfsr_q);
    assign mismatch  = (state_q == RD_REQ) && fpga_ack && (fpga_rd_data != exp_data);

    always_comb begin
        err_d = err_q;
        if (mismatch && (err_q != {ERR_CNT_WIDTH{1'b1}})) begin
            err_d = err_q + ERR_CNT_WIDTH'(1);
        end
    end

    // State register
    always_ff @(posedge fpga_clk or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = WR_REQ;
            end
            WR_REQ: begin
                if (acked)          state_d = last_addr ? RD_GAP : WR_GAP;
                else if (wd_expire) state_d = FINISH;
            end
            WR_GAP: state_d = WR_REQ;
            RD_REQ: begin
                if (acked)          state_d = last_addr ? FINISH : RD_GAP;
                else if (wd_expire) state_d = FINISH;
            end
            RD_GAP: state_d = RD_REQ;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; address and write data are forced to zero outside request cycles.
    always_comb begin
        busy         = (state_q != IDLE);
        done         = (state_q == FINISH);
        fpga_req     = in_req;
        fpga_wr_en   = (state_q == WR_REQ);
        fpga_rd_en   = (state_q == RD_REQ);
        fpga_addr    = in_req ? addr_q : '0;
        fpga_wr_data = (state_q == WR_REQ) ? exp_data : '0;
    end

    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_addr_q;
    assign first_err_data = ferr_data_q;

    // Datapath: address/pattern walker, watchdog and result registers
    always_ff @(posedge fpga_clk or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            addr_q      <= '0;
            lfsr_q      <= '0;
            psel_q      <= 1'b0;
            wd_q        <= '0;
            err_q       <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            // REQ states are only entered from non-REQ states, so this clears on every entry.
            if (!in_req) begin
                wd_q <= '0;
            end else if (!fpga_ack) begin
                wd_q <= wd_q + WD_WIDTH'(1);
            end

            if (launch) begin
                addr_q      <= FIRST_A;
                lfsr_q      <= LFSR_SEED;
                psel_q      <= pattern_sel;
                err_q       <= '0;
                ferr_addr_q <= '0;
                ferr_data_q <= '0;
                pass_q      <= 1'b0;
                timeout_q   <= 1'b0;
            end

            if (acked) begin
                if (last_addr) begin
                    addr_q <= FIRST_A;
                    lfsr_q <= LFSR_SEED;
                end else begin
                    addr_q <= addr_q + FPGA_ADDR_WIDTH'(1);
                    lfsr_q <= lfsr_next;
                end
            end

            if (mismatch) begin
                err_q <= err_d;
                // Saturation never returns to zero, so a zero count means no earlier mismatch.
                if (err_q == '0) begin
                    ferr_addr_q <= addr_q;
                    ferr_data_q <= fpga_rd_data;
                end
            end

            // pass is resolved on the edge entering FINISH so it is valid alongside done.
            if ((state_q == RD_REQ) && acked && last_addr) begin
                pass_q <= (err_d == '0) && !timeout_q;
            end

            if (wd_expire) begin
                timeout_q <= 1'b1;
                pass_q    <= 1'b0;
            end
        end
    end

endmodule
